// File: rtl/timer_dev_if.sv
// timer_dev_if: bus-side connection between the CPU data-bus bridge and one
// countdown timer window.
//
//   addr   byte address from the bridge; the timer decodes only addr[3:2]
//   we     full-word write strobe for this timer window
//   wdata  write data
//   rdata  combinational read data returned to the bridge
//   irq    registered level interrupt request toward CP0
//
// The master modport is the bridge side. The slave modport is the timer side.
interface timer_dev_if #(
    parameter int DW = 32
);
    logic [31:0]   addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload
// modes and a maskable, registered interrupt.
//
//   clk    system clock; all state changes on its rising edge
//   reset  asynchronous, active-high reset
//   bus    timer_dev_if slave port (addr, we, wdata, rdata, irq)
//
// Register map, selected by addr[3:2]:
//   0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//            [3] IM interrupt enable, upper bits read as zero
//   1 PRESET reload value used each time the counter is loaded
//   2 COUNT  current count, read-only
//   3 unmapped, reads zero
module timer_dev #(
    parameter int DW = 32
) (
    input logic       clk,
    input logic       reset,
    timer_dev_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_next;
    logic          ctrl_en;
    logic          ctrl_en_next;
    logic [1:0]    ctrl_mode;
    logic [1:0]    ctrl_mode_next;
    logic          ctrl_im;
    logic          ctrl_im_next;
    logic [DW-1:0] preset;
    logic [DW-1:0] preset_next;
    logic [DW-1:0] count;
    logic [DW-1:0] count_next;
    logic          flag;
    logic          flag_next;
    logic          irq_q;

    // Only addr[3:2] selects a register. The bridge has already decoded
    // the rest of the address for this window.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    // Next-state logic. The FSM step is worked out first. Then a bus write
    // is applied on top of it. Because of that order, software writes to
    // CTRL win over the FSM clearing EN in the same cycle. Writes to CTRL
    // or PRESET also clear the flag. The FSM decisions always use the
    // register values from before the edge. So a PRESET written while
    // counting only takes effect at the next LOAD.
    always_comb begin
        state_next     = state;
        ctrl_en_next   = ctrl_en;
        ctrl_mode_next = ctrl_mode;
        ctrl_im_next   = ctrl_im;
        preset_next    = preset;
        count_next     = count;
        flag_next      = flag;

        case (state)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ctrl_en) begin
                    count_next = preset;
                    state_next = ST_CNT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_next = ST_IDLE;
                end else if (count > ONE) begin
                    count_next = count - ONE;
                end else begin
                    count_next = '0;
                    flag_next  = 1'b1;
                    state_next = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_mode == 2'b01) begin
                    flag_next = 1'b0;
                end else begin
                    ctrl_en_next = 1'b0;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (bus.we) begin
            case (bus.addr[3:2])
                2'd0: begin
                    ctrl_en_next   = bus.wdata[0];
                    ctrl_mode_next = bus.wdata[2:1];
                    ctrl_im_next   = bus.wdata[3];
                    flag_next      = 1'b0;
                end
                2'd1: begin
                    preset_next = bus.wdata;
                    flag_next   = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // State and register update. An asynchronous reset aborts any run
    // immediately and returns every register to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            flag      <= 1'b0;
        end else begin
            state     <= state_next;
            ctrl_en   <= ctrl_en_next;
            ctrl_mode <= ctrl_mode_next;
            ctrl_im   <= ctrl_im_next;
            preset    <= preset_next;
            count     <= count_next;
            flag      <= flag_next;
        end
    end

    // The interrupt is registered from the current flag and mask. A change
    // to either one shows up on irq one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_im & flag;
        end
    end

    assign bus.irq = irq_q;

    // Read data comes straight from the registers. A read in the same
    // cycle as a write therefore returns the old value.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr[3:2])
            2'd0:    bus.rdata = {{(DW-4){1'b0}}, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    bus.rdata = preset;
            2'd2:    bus.rdata = count;
            default: bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: self-checking bench for timer_dev.
//
// Register access is checked from a table of write/read vectors. Random
// timer runs are checked against a timing model built from closed-form
// formulas. Hand-written sequences cover one-shot, auto-reload, masking,
// disable, reset and preset-boundary cases.
module tb_timer_dev;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_UNMAP  = 32'h0000_7F0C;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    // Random-run model parameters.
    int          rP;
    int          rQ;
    int          rMode;
    int          rIm;
    int          rD;
    logic [31:0] rC0 = 32'h0;

    timer_dev_if #(.DW(32)) bus();

    timer_dev #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Guard against a hung simulation.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] r;
        if (v.we) begin
            busWrite(v.waddr, v.wdata);
        end else begin
            tick();
        end
        readReg(v.raddr, r);
        checkOutput(v.name, r, v.expected);
    endtask

    // Timing model. k counts edges after the CTRL write that enables the
    // timer. Q is the effective preset (0 behaves as 1). A run loads at
    // k = 1 + n*(Q+3). COUNT equals P at the following edge and then counts
    // down. The flag rises at k = Q+2 of each period. rD is the edge of the
    // disabling CTRL write.
    function automatic logic flagNoDis(input int k);
        if (rMode != 1) begin
            return k >= rQ + 2;
        end
        return (k >= 2) && (((k - 1) % (rQ + 3)) == rQ + 1);
    endfunction

    function automatic logic expFlag(input int k);
        if (k >= rD) begin
            return 1'b0;
        end
        return flagNoDis(k);
    endfunction

    function automatic logic [31:0] expCount(input int k);
        int ke;
        int m;
        ke = (k >= rD) ? rD : k;
        if (ke <= 1) begin
            return rC0;
        end
        if (rMode != 1) begin
            if (ke <= rQ + 1) begin
                return 32'(rP - ke + 2);
            end
            return 32'h0;
        end
        m = (ke - 1) % (rQ + 3);
        if (m == 0) begin
            return 32'h0;
        end
        if (m <= rQ) begin
            return 32'(rP - (m - 1));
        end
        return 32'h0;
    endfunction

    function automatic logic expEn(input int k);
        if (k >= rD) begin
            return 1'b0;
        end
        if (rMode != 1) begin
            return k < rQ + 3;
        end
        return 1'b1;
    endfunction

    function automatic logic expIrq(input int k);
        return (rIm != 0) && expFlag(k - 1);
    endfunction

    task automatic runRandom();
        int          n;
        logic [31:0] r;
        logic [3:0]  ctrlBits;
        rP    = $urandom_range(0, 12);
        rQ    = (rP == 0) ? 1 : rP;
        rMode = $urandom_range(0, 3);
        rIm   = $urandom_range(0, 1);
        n     = 2 * (rQ + 3) + 6;
        rD    = $urandom_range(2, n);
        if (flagNoDis(rD) && !flagNoDis(rD - 1)) begin
            rD++;
        end
        ctrlBits = {rIm[0], rMode[1:0], 1'b0};
        busWrite(A_PRESET, 32'(rP));
        busWrite(A_CTRL, {28'h0, ctrlBits | 4'b0001});
        for (int k = 1; k <= n + 3; k++) begin
            if (k == rD) begin
                busWrite(A_CTRL, {28'h0, ctrlBits});
            end else begin
                tick();
            end
            readReg(A_COUNT, r);
            checkOutput("rand_count", r, expCount(k));
            readReg(A_CTRL, r);
            checkOutput("rand_ctrl", r, {28'h0, rIm[0], rMode[1:0], expEn(k)});
            checkOutput("rand_irq", {31'h0, bus.irq}, {31'h0, expIrq(k)});
        end
        rC0 = expCount(n + 3);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic        seen;
        int          guard;

        reset     = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Reset state.
        readReg(A_CTRL, r);   checkOutput("reset_ctrl", r, 32'h0);
        readReg(A_PRESET, r); checkOutput("reset_preset", r, 32'h0);
        readReg(A_COUNT, r);  checkOutput("reset_count", r, 32'h0);
        readReg(A_UNMAP, r);  checkOutput("reset_unmapped", r, 32'h0);
        checkOutput("reset_irq", {31'h0, bus.irq}, 32'h0);

        // Register access table. EN stays 0, so COUNT does not move.
        vecs.push_back('{"ctrl_upper_bits", 1'b1, A_CTRL, 32'hFFFF_FFF6, A_CTRL, 32'h0000_0006});
        vecs.push_back('{"preset_rw", 1'b1, A_PRESET, 32'hDEAD_BEEF, A_PRESET, 32'hDEAD_BEEF});
        vecs.push_back('{"count_write_ignored", 1'b1, A_COUNT, 32'h0000_1234, A_COUNT, 32'h0});
        vecs.push_back('{"unmapped_write", 1'b1, A_UNMAP, 32'h0000_FFFF, A_UNMAP, 32'h0});
        vecs.push_back('{"preset_kept", 1'b0, A_CTRL, 32'h0, A_PRESET, 32'hDEAD_BEEF});
        vecs.push_back('{"ctrl_im_only", 1'b1, A_CTRL, 32'h0000_0008, A_CTRL, 32'h0000_0008});
        vecs.push_back('{"second_window", 1'b1, 32'h0000_7F14, 32'h0000_0055, A_PRESET, 32'h0000_0055});
        vecs.push_back('{"preset_zero", 1'b1, A_PRESET, 32'h0, A_PRESET, 32'h0});
        vecs.push_back('{"ctrl_clear", 1'b1, A_CTRL, 32'hFFFF_FFF0, A_CTRL, 32'h0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Randomized runs against the timing model.
        for (int i = 0; i < 25; i++) begin
            runRandom();
        end

        // One-shot: PRESET=5, CTRL=0x9 at edge t (k=0).
        busWrite(A_PRESET, 32'd5);
        busWrite(A_CTRL, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            tick();
            readReg(A_COUNT, r);
            if (k == 2) checkOutput("oneshot_count_t2", r, 32'd5);
            if (k == 6) checkOutput("oneshot_count_t6", r, 32'd1);
            if (k == 7) checkOutput("oneshot_count_t7", r, 32'd0);
            if (k == 9) begin
                readReg(A_CTRL, r);
                checkOutput("oneshot_ctrl_after", r, 32'h8);
            end
            checkOutput("oneshot_irq", {31'h0, bus.irq}, {31'h0, k >= 8});
        end
        busWrite(A_CTRL, 32'h8);
        checkOutput("oneshot_irq_at_clear", {31'h0, bus.irq}, 32'h1);
        tick();
        checkOutput("oneshot_irq_cleared", {31'h0, bus.irq}, 32'h0);

        // Auto-reload: PRESET=5 gives an 8-cycle period.
        busWrite(A_PRESET, 32'd5);
        busWrite(A_CTRL, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            tick();
            checkOutput("auto_irq", {31'h0, bus.irq}, {31'h0, (k >= 8) && ((k - 8) % 8 == 0)});
        end
        readReg(A_CTRL, r);
        checkOutput("auto_en_kept", r, 32'hB);
        busWrite(A_CTRL, 32'h0);
        repeat (3) tick();

        // Masked completion, then unmasked rerun.
        busWrite(A_PRESET, 32'd3);
        busWrite(A_CTRL, 32'h1);
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.irq) seen = 1'b1;
        end
        checkOutput("mask_irq_never", {31'h0, seen}, 32'h0);
        readReg(A_COUNT, r);
        checkOutput("mask_count_zero", r, 32'h0);
        busWrite(A_PRESET, 32'd3);
        busWrite(A_CTRL, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput("unmask_irq", {31'h0, bus.irq}, {31'h0, k >= 6});
        end
        busWrite(A_CTRL, 32'h0);
        repeat (2) tick();

        // Disable mid-count. The write lands one edge after COUNT=60 is
        // seen, so the count freezes at 59.
        busWrite(A_PRESET, 32'd100);
        busWrite(A_CTRL, 32'h9);
        guard = 0;
        r = 32'h0;
        while (r != 32'd60 && guard < 200) begin
            tick();
            readReg(A_COUNT, r);
            guard++;
        end
        checkOutput("disable_reached_60", r, 32'd60);
        busWrite(A_CTRL, 32'h8);
        for (int k = 0; k < 4; k++) begin
            readReg(A_COUNT, r);
            checkOutput("disable_count_frozen", r, 32'd59);
            checkOutput("disable_no_irq", {31'h0, bus.irq}, 32'h0);
            tick();
        end
        readReg(A_CTRL, r);
        checkOutput("disable_ctrl", r, 32'h8);
        busWrite(A_CTRL, 32'h9);
        tick();
        tick();
        readReg(A_COUNT, r);
        checkOutput("reenable_reload", r, 32'd100);
        busWrite(A_CTRL, 32'h0);
        repeat (3) tick();

        // PRESET of 0 and 1 both finish at t+3.
        for (int p = 0; p <= 1; p++) begin
            busWrite(A_PRESET, 32'(p));
            busWrite(A_CTRL, 32'h9);
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k == 2) begin
                    readReg(A_COUNT, r);
                    checkOutput("small_preset_count", r, 32'(p));
                end
                checkOutput("small_preset_irq", {31'h0, bus.irq}, {31'h0, k >= 4});
            end
            busWrite(A_CTRL, 32'h0);
            repeat (2) tick();
        end

        // A PRESET write during CNT affects only the next auto-reload run.
        busWrite(A_PRESET, 32'd10);
        busWrite(A_CTRL, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            if (k == 4) begin
                busWrite(A_PRESET, 32'd7);
            end else begin
                tick();
            end
            readReg(A_COUNT, r);
            if (k == 6)  checkOutput("preset_mid_run_count", r, 32'd6);
            if (k == 15) checkOutput("preset_next_run_count", r, 32'd7);
            checkOutput("preset_mid_irq", {31'h0, bus.irq}, {31'h0, (k == 13) || (k == 23)});
        end
        readReg(A_CTRL, r);
        checkOutput("preset_mid_ctrl", r, 32'hB);

        // Read during a write returns the old value.
        bus.addr  = A_PRESET;
        bus.wdata = 32'h0000_ABCD;
        bus.we    = 1'b1;
        #1;
        checkOutput("read_during_write_old", bus.rdata, 32'd7);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        readReg(A_PRESET, r);
        checkOutput("read_after_write_new", r, 32'h0000_ABCD);
        busWrite(A_CTRL, 32'h0);
        repeat (2) tick();

        // Asynchronous reset in the middle of a run.
        busWrite(A_PRESET, 32'd50);
        busWrite(A_CTRL, 32'h9);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        readReg(A_CTRL, r);   checkOutput("async_reset_ctrl", r, 32'h0);
        readReg(A_PRESET, r); checkOutput("async_reset_preset", r, 32'h0);
        readReg(A_COUNT, r);  checkOutput("async_reset_count", r, 32'h0);
        checkOutput("async_reset_irq", {31'h0, bus.irq}, 32'h0);
        reset = 1'b0;
        repeat (3) tick();
        readReg(A_COUNT, r);
        checkOutput("after_reset_count", r, 32'h0);
        readReg(A_UNMAP, r);
        checkOutput("after_reset_unmapped", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
